collision_monitor: RTL

Parametrised bird/pipe collision monitor for the LED-matrix Flappy Bird game. It checks the bird's row against pipe occupancy in the bird's column and keeps a life counter with a post-hit invulnerability window. It also counts cleared pipes and latches game-over. It sits between the bird/pipe movers and the display/score logic, and replaces the single-life Alive/Dead detector.

---
 rtl/collision_monitor_if.sv | 27 ++
 rtl/collision_monitor.sv | 100 ++++++++++
 2 files changed

// File: rtl/collision_monitor_if.sv
// Bird/pipe collision monitor bus: column occupancy and strobes in,
// hit/invuln/dead/lives/score out.
interface collision_monitor_if #(
  parameter int ROWS    = 8,
  parameter int LIVES   = 3,
  parameter int SCORE_W = 8
);
  logic                         tick;
  logic [ROWS-1:0]              bird_col;
  logic [ROWS-1:0]              pipe_col;
  logic                         pipe_pass;
  logic                         hit;
  logic                         invuln;
  logic                         dead;
  logic [$clog2(LIVES+1)-1:0]   lives;
  logic [SCORE_W-1:0]           score;

  modport master (
    output tick, bird_col, pipe_col, pipe_pass,
    input  hit, invuln, dead, lives, score
  );

  modport slave (
    input  tick, bird_col, pipe_col, pipe_pass,
    output hit, invuln, dead, lives, score
  );
endinterface

// File: rtl/collision_monitor.sv
// Multi-life collision monitor for the LED-matrix Flappy Bird game: life
// counter with post-hit grace window, saturating pipe score, sticky game-over.
module collision_monitor #(
  parameter int ROWS        = 8,
  parameter int LIVES       = 3,
  parameter int GRACE_TICKS = 4,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  collision_monitor_if.slave bus
);
  localparam int LW = $clog2(LIVES + 1);
  localparam int GW = $clog2(GRACE_TICKS + 1);

  typedef enum logic [1:0] {ALIVE, GRACE, DEAD} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     lives_q, lives_d;
  logic [GW-1:0]     grace_q, grace_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic              hit_q, hit_d;

  logic [ROWS-1:0]   overlap;
  logic              coll, oob;
  logic [SCORE_W-1:0] score_inc;

  assign overlap   = bus.bird_col & bus.pipe_col;
  assign coll      = |overlap;
  assign oob       = ~|bus.bird_col;
  assign score_inc = (&score_q) ? score_q : score_q + SCORE_W'(1);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    grace_d = grace_q;
    score_d = score_q;
    hit_d   = 1'b0;
    case (state_q)
      ALIVE: begin
        if (oob) begin
          lives_d = '0;
          state_d = DEAD;
          hit_d   = 1'b1;
        end else if (coll) begin
          // A hit swallows any same-cycle pipe_pass.
          hit_d = 1'b1;
          if (lives_q == LW'(1)) begin
            lives_d = '0;
            state_d = DEAD;
          end else begin
            lives_d = lives_q - LW'(1);
            grace_d = GW'(GRACE_TICKS);
            state_d = GRACE;
          end
        end else if (bus.pipe_pass) begin
          score_d = score_inc;
        end
      end
      GRACE: begin
        if (oob) begin
          lives_d = '0;
          state_d = DEAD;
          hit_d   = 1'b1;
        end else begin
          if (bus.pipe_pass) score_d = score_inc;
          // Collisions are not looked at here, even on the expiry cycle.
          if (bus.tick) begin
            grace_d = grace_q - GW'(1);
            if (grace_q == GW'(1)) state_d = ALIVE;
          end
        end
      end
      DEAD: ;
      default: state_d = ALIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ALIVE;
      lives_q <= LW'(LIVES);
      grace_q <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      grace_q <= grace_d;
      score_q <= score_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.hit    = hit_q;
  assign bus.invuln = (state_q == GRACE);
  assign bus.dead   = (state_q == DEAD);
  assign bus.lives  = lives_q;
  assign bus.score  = score_q;
endmodule
